// File: rtl/tft_rx_monitor.sv
// Panel-side checker: rebuilds x/y from data-enable framing, checks line length/period/count, sums pixels per frame.
// Latency: pix_valid/x/y 2 cycles after the data-enable sample; frame_done 2 cycles after the H_TOTAL-th idle sample.
// Backpressure: none, the pixel stream cannot be stalled; every cycle is observed.
module tft_rx_monitor #(
  parameter int H_ACTIVE = 480,
  parameter int V_ACTIVE = 272,
  parameter int H_TOTAL  = 525
) (
  input  logic        tft_clk,
  input  logic        rstb,
  input  logic        tft_data_ena,
  input  logic [7:0]  tft_red,
  input  logic [7:0]  tft_green,
  input  logic [7:0]  tft_blue,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        pix_valid,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [15:0] checksum,
  output logic        line_err,
  output logic [15:0] frame_count,
  output logic [7:0]  err_count
);

  localparam logic [9:0] HA      = 10'(H_ACTIVE);
  localparam logic [9:0] HT      = 10'(H_TOTAL);
  localparam logic [9:0] HT_M1   = 10'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST  = 9'(V_ACTIVE - 1);
  localparam logic [9:0] CNT_MAX = 10'd1023;

  typedef enum logic [1:0] {SYNC, VBLANK, ACTIVE, HBLANK} state_t;

  state_t      state, state_nxt;
  logic        de_q, de_d;
  logic [7:0]  r_q, g_q, b_q;
  logic [9:0]  x_cnt, idle_cnt, per_cnt;
  logic [8:0]  y_cnt, y_inc;
  logic [15:0] sum, pix_sum;
  logic        rise, y_sat, ok;
  logic        frame_start, line_start, line_end, frame_end, accept;

  assign rise    = de_q & ~de_d;
  assign pix_sum = {8'd0, r_q} + {8'd0, g_q} + {8'd0, b_q};
  assign y_sat   = (y_cnt == V_LAST);
  assign y_inc   = y_sat ? y_cnt : y_cnt + 9'd1;
  // y_cnt only reaches V_LAST with exactly V_ACTIVE lines; extra lines already raised line_err
  assign ok      = y_sat && !line_err;

  always_ff @(posedge tft_clk or negedge rstb) begin
    if (!rstb) state <= SYNC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    line_start  = 1'b0;
    line_end    = 1'b0;
    frame_end   = 1'b0;
    accept      = 1'b0;
    case (state)
      SYNC: begin
        if (!de_q && idle_cnt == HT_M1) state_nxt = VBLANK;
      end
      VBLANK: begin
        if (rise) begin
          frame_start = 1'b1;
          accept      = 1'b1;
          state_nxt   = ACTIVE;
        end
      end
      ACTIVE: begin
        if (de_q) begin
          accept = 1'b1;
        end else begin
          line_end  = 1'b1;
          state_nxt = HBLANK;
        end
      end
      HBLANK: begin
        // frame end wins over a coincident rise; that rise is left for VBLANK to ignore
        if (!de_q && idle_cnt == HT_M1) begin
          frame_end = 1'b1;
          state_nxt = VBLANK;
        end else if (rise) begin
          line_start = 1'b1;
          accept     = 1'b1;
          state_nxt  = ACTIVE;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge tft_clk or negedge rstb) begin
    if (!rstb) begin
      de_q        <= 1'b0;
      de_d        <= 1'b0;
      r_q         <= 8'd0;
      g_q         <= 8'd0;
      b_q         <= 8'd0;
      idle_cnt    <= 10'd0;
      per_cnt     <= 10'd0;
      x_cnt       <= 10'd0;
      y_cnt       <= 9'd0;
      sum         <= 16'd0;
      x           <= 10'd0;
      y           <= 9'd0;
      pix_valid   <= 1'b0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      checksum    <= 16'd0;
      line_err    <= 1'b0;
      frame_count <= 16'd0;
      err_count   <= 8'd0;
    end else begin
      de_q       <= tft_data_ena;
      de_d       <= de_q;
      r_q        <= tft_red;
      g_q        <= tft_green;
      b_q        <= tft_blue;
      pix_valid  <= accept;
      frame_done <= frame_end;

      if (de_q)                     idle_cnt <= 10'd0;
      else if (idle_cnt != CNT_MAX) idle_cnt <= idle_cnt + 10'd1;

      if (frame_start || line_start) per_cnt <= 10'd1;
      else if (per_cnt != CNT_MAX)   per_cnt <= per_cnt + 10'd1;

      if (frame_start) begin
        x_cnt    <= 10'd1;
        y_cnt    <= 9'd0;
        x        <= 10'd0;
        y        <= 9'd0;
        sum      <= pix_sum;
        line_err <= 1'b0;
      end else if (line_start) begin
        x_cnt <= 10'd1;
        y_cnt <= y_inc;
        x     <= 10'd0;
        y     <= y_inc;
        sum   <= sum + pix_sum;
        if (per_cnt != HT || y_sat) line_err <= 1'b1;
      end else if (accept) begin
        x   <= x_cnt;
        y   <= y_cnt;
        sum <= sum + pix_sum;
        if (x_cnt != CNT_MAX) x_cnt <= x_cnt + 10'd1;
      end

      if (line_end && x_cnt != HA) line_err <= 1'b1;

      if (frame_end) begin
        checksum    <= sum;
        frame_ok    <= ok;
        frame_count <= frame_count + 16'd1;
        if (!ok && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_tft_rx_monitor.sv
// Bench for tft_rx_monitor on a reduced raster (20x8 active, 26-clock lines) so every scenario fits a short run.
// Drivers push expected pixels/frames to queues; a negedge monitor pops and compares them as the DUT reports.
module tb_tft_rx_monitor;
  localparam int HA = 20;
  localparam int VA = 8;
  localparam int HT = 26;

  logic        tft_clk = 1'b0;
  logic        rstb = 1'b0;
  logic        tft_data_ena = 1'b0;
  logic [7:0]  tft_red = 8'd0, tft_green = 8'd0, tft_blue = 8'd0;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        pix_valid, frame_done, frame_ok, line_err;
  logic [15:0] checksum, frame_count;
  logic [7:0]  err_count;

  typedef struct { int x; int y; int t; } pix_exp_t;
  typedef struct { logic ok; logic [15:0] cs; logic [15:0] fc; logic [7:0] ec; int t; } frm_exp_t;

  pix_exp_t    pix_q[$];
  frm_exp_t    frm_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [15:0] exp_fc = 16'd0;
  logic [15:0] cur_cs = 16'd0;
  logic [7:0]  exp_ec = 8'd0;
  logic        prev_fd = 1'b0;

  tft_rx_monitor #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT)) dut (
    .tft_clk(tft_clk), .rstb(rstb), .tft_data_ena(tft_data_ena),
    .tft_red(tft_red), .tft_green(tft_green), .tft_blue(tft_blue),
    .x(x), .y(y), .pix_valid(pix_valid), .frame_done(frame_done),
    .frame_ok(frame_ok), .checksum(checksum), .line_err(line_err),
    .frame_count(frame_count), .err_count(err_count)
  );

  always #5 tft_clk = ~tft_clk;
  always @(posedge tft_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got no summary by %0t, required completion", $time);
    $fatal(1);
  end

  always @(negedge tft_clk) begin
    pix_exp_t pe;
    frm_exp_t fe;
    if (pix_valid) begin
      n_cmp++;
      if (pix_q.size() == 0) begin
        n_fail++;
        $display("FAIL pixel_unexpected: got x=%0d y=%0d at cycle %0d, required no pixel", x, y, cyc);
      end else begin
        pe = pix_q.pop_front();
        if (x !== 10'(pe.x) || y !== 9'(pe.y) || cyc != pe.t) begin
          n_fail++;
          $display("FAIL pixel: got x=%0d y=%0d cycle=%0d, required x=%0d y=%0d cycle=%0d", x, y, cyc, pe.x, pe.y, pe.t);
        end
      end
    end
    if (frame_done) begin
      n_cmp++;
      if (frm_q.size() == 0) begin
        n_fail++;
        $display("FAIL frame_unexpected: got frame_done at cycle %0d, required none", cyc);
      end else begin
        fe = frm_q.pop_front();
        if (frame_ok !== fe.ok || checksum !== fe.cs || frame_count !== fe.fc || err_count !== fe.ec || cyc != fe.t) begin
          n_fail++;
          $display("FAIL frame: got ok=%0b cs=%h fc=%0d ec=%0d cycle=%0d, required ok=%0b cs=%h fc=%0d ec=%0d cycle=%0d",
                   frame_ok, checksum, frame_count, err_count, cyc, fe.ok, fe.cs, fe.fc, fe.ec, fe.t);
        end
      end
      n_cmp++;
      if (prev_fd) begin
        n_fail++;
        $display("FAIL frame_done_width: got high for 2+ cycles at cycle %0d, required 1 cycle", cyc);
      end
    end
    prev_fd = frame_done;
  end

  function automatic logic [23:0] pix_rgb(input int pat, input int l, input int c);
    case (pat)
      0:       return 24'h010203;
      1:       return (l == 3 && c == 17) ? 24'hFF0000 : 24'h000000;
      default: return 24'($urandom);
    endcase
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge tft_clk);
      tft_data_ena = 1'b0;
      tft_red = 8'd0; tft_green = 8'd0; tft_blue = 8'd0;
    end
  endtask

  task automatic drive_line(input int l, input int npix, input int nidle, input int pat);
    logic [23:0] rgb;
    pix_exp_t    pe;
    for (int c = 0; c < npix; c++) begin
      @(negedge tft_clk);
      rgb = pix_rgb(pat, l, c);
      tft_data_ena = 1'b1;
      tft_red = rgb[23:16]; tft_green = rgb[15:8]; tft_blue = rgb[7:0];
      cur_cs = cur_cs + 16'(rgb[23:16]) + 16'(rgb[15:8]) + 16'(rgb[7:0]);
      pe.x = (c > 1023) ? 1023 : c;
      pe.y = (l > VA - 1) ? VA - 1 : l;
      pe.t = cyc + 2;
      pix_q.push_back(pe);
    end
    idle(nidle);
  endtask

  // one frame plus a blank long enough to end it; bad_line < 0 means every line nominal
  task automatic drive_frame(input int nlines, input int pat, input int bad_line, input int bad_npix, input int bad_period);
    bit       ok;
    int       npix, per;
    frm_exp_t fe;
    cur_cs = 16'd0;
    ok = (nlines == VA);
    for (int l = 0; l < nlines; l++) begin
      npix = (l == bad_line) ? bad_npix : HA;
      per  = (l == bad_line) ? bad_period : HT;
      if (npix != HA) ok = 0;
      if (l < nlines - 1 && per != HT) ok = 0;
      drive_line(l, npix, (l < nlines - 1) ? per - npix : 0, pat);
    end
    for (int i = 1; i <= HT + 4; i++) begin
      @(negedge tft_clk);
      tft_data_ena = 1'b0;
      tft_red = 8'd0; tft_green = 8'd0; tft_blue = 8'd0;
      if (i == HT) begin
        exp_fc = exp_fc + 16'd1;
        if (!ok && exp_ec != 8'd255) exp_ec = exp_ec + 8'd1;
        fe.ok = ok; fe.cs = cur_cs; fe.fc = exp_fc; fe.ec = exp_ec; fe.t = cyc + 2;
        frm_q.push_back(fe);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge tft_clk);
      tft_data_ena = 1'b1; tft_red = 8'hAA; tft_green = 8'h55; tft_blue = 8'h11;
    end
    n_cmp++;
    if ({x, y, pix_valid, frame_done, frame_ok, checksum, line_err, frame_count, err_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got x=%0d y=%0d pv=%0b fd=%0b ok=%0b cs=%h le=%0b fc=%0d ec=%0d, required all 0",
               x, y, pix_valid, frame_done, frame_ok, checksum, line_err, frame_count, err_count);
    end
    @(negedge tft_clk);
    rstb = 1'b1;
    // pixels during SYNC must not be accepted; the monitor flags any that appear
    drive_line(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge tft_clk);
      tft_data_ena = 1'b1;
    end
    idle(HT + 3);
  endtask

  task automatic test_nominal();
    drive_frame(VA, 0, -1, 0, 0);
    drive_frame(VA, 0, -1, 0, 0);
    n_cmp++;
    if (frame_ok !== 1'b1 || checksum !== 16'(HA * VA * 6) || frame_count !== 16'd2 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL nominal: got ok=%0b cs=%h fc=%0d ec=%0d, required ok=1 cs=%h fc=2 ec=0",
               frame_ok, checksum, frame_count, err_count, 16'(HA * VA * 6));
    end
  endtask

  task automatic test_single_pixel();
    drive_frame(VA, 1, -1, 0, 0);
    n_cmp++;
    if (checksum !== 16'h00FF || frame_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL single_pixel: got cs=%h ok=%0b, required cs=00ff ok=1", checksum, frame_ok);
    end
  endtask

  task automatic test_short_line();
    drive_frame(VA, 2, 5, HA - 1, HT);
    n_cmp++;
    if (frame_ok !== 1'b0 || line_err !== 1'b1 || err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL short_line: got ok=%0b le=%0b ec=%0d, required ok=0 le=1 ec=1", frame_ok, line_err, err_count);
    end
  endtask

  task automatic test_long_period();
    logic prev_le;
    bit   found;
    drive_frame(VA, 2, 2, HA, HT + 1);
    n_cmp++;
    if (frame_ok !== 1'b0 || line_err !== 1'b1) begin
      n_fail++;
      $display("FAIL long_period: got ok=%0b le=%0b, required ok=0 le=1", frame_ok, line_err);
    end
    prev_le = line_err;
    found = 0;
    fork
      drive_frame(VA, 0, -1, 0, 0);
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge tft_clk);
          if (pix_valid) begin
            found = 1;
            break;
          end
          prev_le = line_err;
        end
        n_cmp++;
        if (!found || prev_le !== 1'b1 || line_err !== 1'b0) begin
          n_fail++;
          $display("FAIL line_err_clear: got found=%0b before=%0b at_first_pixel=%0b, required found=1 before=1 at_first_pixel=0",
                   found, prev_le, line_err);
        end
      end
    join
    n_cmp++;
    if (frame_ok !== 1'b1 || err_count !== 8'd2) begin
      n_fail++;
      $display("FAIL recover: got ok=%0b ec=%0d, required ok=1 ec=2", frame_ok, err_count);
    end
  endtask

  task automatic test_line_count();
    drive_frame(VA - 1, 2, -1, 0, 0);
    n_cmp++;
    if (frame_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL short_frame: got ok=%0b, required ok=0", frame_ok);
    end
    drive_frame(VA + 1, 2, -1, 0, 0);
    n_cmp++;
    if (frame_ok !== 1'b0 || y !== 9'(VA - 1) || err_count !== 8'd4) begin
      n_fail++;
      $display("FAIL long_frame: got ok=%0b y=%0d ec=%0d, required ok=0 y=%0d ec=4", frame_ok, y, err_count, VA - 1);
    end
  endtask

  task automatic test_reset_mid();
    for (int l = 0; l < 5; l++) drive_line(l, HA, HT - HA, 2);
    drive_line(5, 12, 0, 2);
    #3;
    rstb = 1'b0;
    #1;
    n_cmp++;
    if ({x, y, pix_valid, frame_done, frame_ok, checksum, line_err, frame_count, err_count} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got x=%0d y=%0d pv=%0b fd=%0b ok=%0b cs=%h le=%0b fc=%0d ec=%0d, required all 0",
               x, y, pix_valid, frame_done, frame_ok, checksum, line_err, frame_count, err_count);
    end
    pix_q.delete();
    exp_fc = 16'd0;
    exp_ec = 8'd0;
    idle(2);
    rstb = 1'b1;
    idle(HT + 3);
    drive_frame(VA, 0, -1, 0, 0);
    n_cmp++;
    if (frame_ok !== 1'b1 || frame_count !== 16'd1) begin
      n_fail++;
      $display("FAIL after_reset: got ok=%0b fc=%0d, required ok=1 fc=1", frame_ok, frame_count);
    end
  endtask

  task automatic test_err_saturation();
    for (int i = 0; i < 256; i++) drive_frame(1, 0, -1, 0, 0);
    n_cmp++;
    if (err_count !== 8'd255 || frame_count !== 16'd257) begin
      n_fail++;
      $display("FAIL err_saturation: got ec=%0d fc=%0d, required ec=255 fc=257", err_count, frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_single_pixel();
    test_short_line();
    test_long_period();
    test_line_count();
    test_reset_mid();
    test_err_saturation();
    repeat (5) @(negedge tft_clk);
    n_cmp++;
    if (pix_q.size() != 0 || frm_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pixels / %0d frames outstanding, required 0 / 0", pix_q.size(), frm_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
